// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared types and constants for the instruction fetch sequencer.
// Holds the fetch state encoding, instruction width and the NOP word.
package instr_fetch_pkg;

    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/instr_ram.sv
// instr_ram: one write port, one synchronous read port, read-first.
// A same-address write and read in one cycle returns the old word.
module instr_ram
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = INSTR_WIDTH
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // storage write and registered read; the read sees pre-write contents
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: streams the stored program to the decoder on each sample tick.
// Define INSTR_FETCH_DOUBLE_BUFFER_EN for active/shadow program banks.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int N_INSTRS = 256,
    parameter int ADDR_W   = $clog2(N_INSTRS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sample_tick,
    input  logic [ADDR_W:0]        prog_len,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [INSTR_WIDTH-1:0] wr_data,
    input  logic                   bank_swap,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [ADDR_W-1:0]      pc_out,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam logic [ADDR_W:0] LEN_ONE = 1;

    fetch_state_t state_q, state_d;

    logic [ADDR_W:0]        len_q;
    logic [ADDR_W:0]        pc_q;
    logic                   rd_vld_q;
    logic [ADDR_W-1:0]      rd_pc_q;
    logic [INSTR_WIDTH-1:0] rdata;
    logic [1:0]             cnt_q;
    logic [INSTR_WIDTH-1:0] buf_data_q [2];
    logic [ADDR_W-1:0]      buf_pc_q [2];
    logic                   done_q;
    logic                   overrun_q;

    logic [1:0] occ;
    logic       pop;
    logic       pop_buf;
    logic       push;
    logic       issue;
    logic       last_xfer;
    logic       tick_go;
    logic       len_zero;

    // words held or in flight; reads stop once both skid slots are claimed
    assign occ       = cnt_q + {1'b0, rd_vld_q};
    assign pop       = instr_valid && instr_ready;
    assign pop_buf   = pop && (cnt_q != 2'd0);
    assign push      = rd_vld_q && !(pop && (cnt_q == 2'd0));
    assign issue     = (state_q == RUN) && (occ <= 2'd1);
    assign last_xfer = (state_q == DRAIN) && pop && (occ == 2'd1);
    assign tick_go   = sample_tick && ((state_q == IDLE) || last_xfer);
    assign len_zero  = (prog_len == '0);

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign instr_valid = (cnt_q != 2'd0) || rd_vld_q;

    // head of the skid buffer, else the word arriving from the RAM
    always_comb begin
        instr  = '0;
        pc_out = '0;
        if (cnt_q != 2'd0) begin
            instr  = buf_data_q[0];
            pc_out = buf_pc_q[0];
        end else if (rd_vld_q) begin
            instr  = rdata;
            pc_out = rd_pc_q;
        end
    end

    // next-state: start on tick, drain after the last read, restart on coincident tick
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sample_tick && !len_zero) state_d = RUN;
            end
            RUN: begin
                if (issue && (pc_q == len_q - LEN_ONE)) state_d = DRAIN;
            end
            DRAIN: begin
                if (last_xfer) begin
                    state_d = (sample_tick && !len_zero) ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, program counter, read pipeline and status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            pc_q      <= '0;
            rd_vld_q  <= 1'b0;
            rd_pc_q   <= '0;
            cnt_q     <= 2'd0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= issue;
            if (issue) rd_pc_q <= pc_q[ADDR_W-1:0];
            if (tick_go) begin
                len_q <= prog_len;
                pc_q  <= '0;
            end else if (issue) begin
                pc_q <= pc_q + LEN_ONE;
            end
            cnt_q     <= cnt_q - {1'b0, pop_buf} + {1'b0, push};
            done_q    <= last_xfer ||
                         (sample_tick && (state_q == IDLE) && len_zero);
            overrun_q <= sample_tick && busy && !last_xfer;
        end
    end

    // skid slots: shift on pop, park an unaccepted RAM word in the next free slot
    always_ff @(posedge clk) begin
        if (pop_buf) begin
            buf_data_q[0] <= buf_data_q[1];
            buf_pc_q[0]   <= buf_pc_q[1];
        end
        if (push) begin
            if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop_buf)) begin
                buf_data_q[0] <= rdata;
                buf_pc_q[0]   <= rd_pc_q;
            end else begin
                buf_data_q[1] <= rdata;
                buf_pc_q[1]   <= rd_pc_q;
            end
        end
    end

`ifdef INSTR_FETCH_DOUBLE_BUFFER_EN
    logic                   bank_q;
    logic                   pend_q;
    logic [INSTR_WIDTH-1:0] rdata0;
    logic [INSTR_WIDTH-1:0] rdata1;

    // swap banks at an accepted tick so a run never mixes programs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_q <= 1'b0;
            pend_q <= 1'b0;
        end else if (tick_go && pend_q) begin
            bank_q <= ~bank_q;
            pend_q <= bank_swap;
        end else if (bank_swap) begin
            pend_q <= 1'b1;
        end
    end

    instr_ram #(.DEPTH(N_INSTRS), .AW(ADDR_W)) u_ram0 (
        .clk   (clk),
        .we    (wr_en && bank_q),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (pc_q[ADDR_W-1:0]),
        .rdata (rdata0)
    );

    instr_ram #(.DEPTH(N_INSTRS), .AW(ADDR_W)) u_ram1 (
        .clk   (clk),
        .we    (wr_en && !bank_q),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (pc_q[ADDR_W-1:0]),
        .rdata (rdata1)
    );

    assign rdata = bank_q ? rdata1 : rdata0;
`else
    logic unused_swap;
    assign unused_swap = bank_swap;

    instr_ram #(.DEPTH(N_INSTRS), .AW(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (pc_q[ADDR_W-1:0]),
        .rdata (rdata)
    );
`endif

endmodule
